// File: rtl/orb_hamming_matcher.sv
// Brute-force ORB matcher: per image-0 descriptor, scans all image-1 descriptors for the
// minimum 256-bit Hamming distance and streams records that pass MAX_DISTANCE.
module orb_hamming_matcher #(
  parameter int MAX_DISTANCE = 64,
  parameter int MAX_LENGTH   = 2048
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_desc_0_ready,
  output logic         o_desc_0_ready_ack,
  input  logic [15:0]  i_desc_0_length,
  output logic         o_desc_0_en,
  output logic [15:0]  o_desc_0_address,
  input  logic [255:0] i_desc_0_data,
  output logic         o_desc_0_location_en,
  output logic [15:0]  o_desc_0_location_address,
  input  logic [31:0]  i_desc_0_location_data,
  input  logic         i_desc_1_ready,
  output logic         o_desc_1_ready_ack,
  input  logic [15:0]  i_desc_1_length,
  output logic         o_desc_1_en,
  output logic [15:0]  o_desc_1_address,
  input  logic [255:0] i_desc_1_data,
  output logic         o_desc_1_location_en,
  output logic [15:0]  o_desc_1_location_address,
  input  logic [31:0]  i_desc_1_location_data,
  output logic         o_match_start,
  output logic         o_match_end,
  output logic         o_match_valid,
  output logic [63:0]  o_match_value,
  output logic [8:0]   o_match_distance
);
  localparam int AW = $clog2(MAX_LENGTH);
  localparam int LW = AW + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_LOAD0, S_LWAIT, S_LCAP, S_SCAN,
    S_DRAIN, S_EVAL, S_LOC1W, S_LOC1C, S_DONE
  } state_t;

  state_t           r_state;
  logic [LW-1:0]    r_l0, r_l1, r_i, r_j;
  logic [255:0]     r_desc0;
  logic [31:0]      r_loc0;
  logic [9:0]       r_best_dist;
  logic [AW-1:0]    r_best_j;
  logic             r_ack, r_start, r_end, r_valid;
  logic             r_d0_en, r_d1_en, r_d1_loc_en;
  logic [AW-1:0]    r_d0_addr, r_d1_addr, r_d1_loc_addr;
  logic [63:0]      r_value;
  logic [8:0]       r_dist;
  logic             r_iss_last;
  logic             r_rd_vld, r_rd_last, r_s1_vld, r_s1_last, r_s2_vld, r_s2_last;
  logic [AW-1:0]    r_rd_j, r_s1_j, r_s2_j;
  logic [15:0][4:0] r_s1_cnt;
  logic [8:0]       r_s2_dist;

  logic [LW-1:0]    w_len0, w_len1, w_i_next;
  logic [255:0]     w_x;
  logic [15:0][4:0] w_cnt;
  logic [8:0]       w_sum;

  assign w_len0   = (i_desc_0_length > 16'(MAX_LENGTH)) ? LW'(MAX_LENGTH) : i_desc_0_length[LW-1:0];
  assign w_len1   = (i_desc_1_length > 16'(MAX_LENGTH)) ? LW'(MAX_LENGTH) : i_desc_1_length[LW-1:0];
  assign w_i_next = r_i + LW'(1);

  // Stage 1: XOR plus 16 independent 16-bit popcounts; stage 2 adds the partials.
  always_comb begin
    w_x = i_desc_1_data ^ r_desc0;
    for (int k = 0; k < 16; k++) begin
      w_cnt[k] = '0;
      for (int b = 0; b < 16; b++) w_cnt[k] = w_cnt[k] + 5'(w_x[16*k+b]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 16; k++) w_sum = w_sum + 9'(r_s1_cnt[k]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_l0 <= '0; r_l1 <= '0; r_i <= '0; r_j <= '0;
      r_desc0 <= '0; r_loc0 <= '0; r_best_dist <= '0; r_best_j <= '0;
      r_ack <= 1'b0; r_start <= 1'b0; r_end <= 1'b0; r_valid <= 1'b0;
      r_d0_en <= 1'b0; r_d1_en <= 1'b0; r_d1_loc_en <= 1'b0;
      r_d0_addr <= '0; r_d1_addr <= '0; r_d1_loc_addr <= '0;
      r_value <= '0; r_dist <= '0; r_iss_last <= 1'b0;
      r_rd_vld <= 1'b0; r_rd_last <= 1'b0; r_rd_j <= '0;
      r_s1_vld <= 1'b0; r_s1_last <= 1'b0; r_s1_j <= '0; r_s1_cnt <= '0;
      r_s2_vld <= 1'b0; r_s2_last <= 1'b0; r_s2_j <= '0; r_s2_dist <= '0;
    end else begin
      r_ack <= 1'b0; r_start <= 1'b0; r_end <= 1'b0; r_valid <= 1'b0;
      r_d0_en <= 1'b0; r_d1_en <= 1'b0; r_d1_loc_en <= 1'b0; r_iss_last <= 1'b0;

      // Read data is valid the cycle after the registered enable is seen.
      r_rd_vld  <= r_d1_en;   r_rd_last <= r_iss_last; r_rd_j <= r_d1_addr;
      r_s1_vld  <= r_rd_vld;  r_s1_last <= r_rd_last;  r_s1_j <= r_rd_j; r_s1_cnt <= w_cnt;
      r_s2_vld  <= r_s1_vld;  r_s2_last <= r_s1_last;  r_s2_j <= r_s1_j; r_s2_dist <= w_sum;
      if (r_s2_vld && ({1'b0, r_s2_dist} < r_best_dist)) begin
        r_best_dist <= {1'b0, r_s2_dist};
        r_best_j    <= r_s2_j;
      end

      case (r_state)
        S_IDLE: if (i_desc_0_ready && i_desc_1_ready) begin
          r_ack   <= 1'b1;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_l0    <= w_len0;
          r_l1    <= w_len1;
          r_start <= 1'b1;
          r_i     <= '0;
          r_state <= (w_len0 == '0 || w_len1 == '0) ? S_DONE : S_LOAD0;
        end
        S_LOAD0: begin
          r_d0_en     <= 1'b1;
          r_d0_addr   <= r_i[AW-1:0];
          r_best_dist <= 10'd257;
          r_best_j    <= '0;
          r_state     <= S_LWAIT;
        end
        S_LWAIT: r_state <= S_LCAP;
        S_LCAP: begin
          r_desc0 <= i_desc_0_data;
          r_loc0  <= i_desc_0_location_data;
          r_j     <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          r_d1_en    <= 1'b1;
          r_d1_addr  <= r_j[AW-1:0];
          r_iss_last <= (r_j == r_l1 - LW'(1));
          r_j        <= r_j + LW'(1);
          if (r_j == r_l1 - LW'(1)) r_state <= S_DRAIN;
        end
        // The last compare lands on this edge, so best is final in EVAL.
        S_DRAIN: if (r_s2_vld && r_s2_last) r_state <= S_EVAL;
        S_EVAL: begin
          if (r_best_dist <= 10'(MAX_DISTANCE)) begin
            r_d1_loc_en   <= 1'b1;
            r_d1_loc_addr <= r_best_j;
            r_state       <= S_LOC1W;
          end else begin
            r_i     <= w_i_next;
            r_state <= (w_i_next == r_l0) ? S_DONE : S_LOAD0;
          end
        end
        S_LOC1W: r_state <= S_LOC1C;
        S_LOC1C: begin
          r_valid <= 1'b1;
          r_value <= {r_loc0, i_desc_1_location_data};
          r_dist  <= r_best_dist[8:0];
          r_i     <= w_i_next;
          r_state <= (w_i_next == r_l0) ? S_DONE : S_LOAD0;
        end
        S_DONE: begin
          r_end   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_desc_0_ready_ack        = r_ack;
  assign o_desc_1_ready_ack        = r_ack;
  assign o_desc_0_en               = r_d0_en;
  assign o_desc_0_address          = {{(16-AW){1'b0}}, r_d0_addr};
  assign o_desc_0_location_en      = r_d0_en;
  assign o_desc_0_location_address = {{(16-AW){1'b0}}, r_d0_addr};
  assign o_desc_1_en               = r_d1_en;
  assign o_desc_1_address          = {{(16-AW){1'b0}}, r_d1_addr};
  assign o_desc_1_location_en      = r_d1_loc_en;
  assign o_desc_1_location_address = {{(16-AW){1'b0}}, r_d1_loc_addr};
  assign o_match_start             = r_start;
  assign o_match_end               = r_end;
  assign o_match_valid             = r_valid;
  assign o_match_value             = r_value;
  assign o_match_distance          = r_dist;
endmodule

// File: doc/orb_hamming_matcher.md
Name: orb_hamming_matcher

Overview:
- Brute-force ORB matcher directly downstream of the dual-image descriptor buffer.
- On handshake with both buffers, it reads each image-0 descriptor and scans every image-1 descriptor for the minimum 256-bit Hamming distance.
- It emits one match record per image-0 descriptor whose best distance passes the threshold.
- Records go to the match filter / output packer stage as a start/valid/end stream.

Parameters:
- MAX_DISTANCE, 64, accept threshold; a match is emitted only when best distance <= MAX_DISTANCE.
- MAX_LENGTH, 2048, buffer depth; input lengths are clamped to this value.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_desc_0_ready  in  1  image-0 buffer holds a complete frame
- o_desc_0_ready_ack  out  1  one-cycle acknowledge to image-0 buffer
- i_desc_0_length  in  16  image-0 descriptor count
- o_desc_0_en  out  1  image-0 descriptor read enable
- o_desc_0_address  out  16  image-0 descriptor read address
- i_desc_0_data  in  256  image-0 descriptor; valid 1 cycle after en
- o_desc_0_location_en  out  1  image-0 location read enable
- o_desc_0_location_address  out  16  image-0 location read address
- i_desc_0_location_data  in  32  image-0 {x,y}; valid 1 cycle after en
- i_desc_1_* / o_desc_1_*  (same set)  image-1 counterparts with identical widths and timing
- o_match_start  out  1  one-cycle pulse at the start of a frame's match stream
- o_match_end  out  1  one-cycle pulse after the last record
- o_match_valid  out  1  record strobe
- o_match_value  out  64  {loc0[31:0], loc1[31:0]}
- o_match_distance  out  9  best Hamming distance, range 0..256

Behaviour:
- Reset (sync, i_rst=1): FSM goes to IDLE. All outputs are 0 from the next edge. Indices and best registers clear. No ack is issued. Reset mid-scan abandons the frame without emitting o_match_end.
- Read timing: all RAM reads have 1-cycle latency. Address and enable are registered outputs.
- IDLE: wait for i_desc_0_ready && i_desc_1_ready both high in the same cycle. Then move to ACK.
- ACK:
  - Pulse both o_desc_*_ready_ack for exactly 1 cycle.
  - Latch L0 and L1 as min(length, MAX_LENGTH).
  - Pulse o_match_start on the following cycle.
  - Set i=0. If L0==0 or L1==0, go to DONE; otherwise go to LOAD0.
- LOAD0: read desc_0[i] and loc_0[i]; register both when returned. Set best_dist=257 and best_j=0. Go to SCAN.
- SCAN:
  - Issue desc_1 reads for j=0..L1-1, one per cycle, no bubbles.
  - Pipeline per j: data XOR desc0 -> popcount, registered over 2 stages -> compare.
  - Update rule is strictly less: dist<best_dist replaces; on ties the lowest j wins.
  - After the last compare drains, go to EVAL.
- EVAL:
  - If best_dist<=MAX_DISTANCE: read loc_1[best_j]. One cycle after the data returns, assert o_match_valid for 1 cycle with o_match_value={loc0,loc1} and o_match_distance=best_dist.
  - Otherwise emit nothing.
  - Then i=i+1. If i==L0, go to DONE; else go to LOAD0.
- DONE: pulse o_match_end for 1 cycle, then return to IDLE.
- Throughput: one comparison per cycle. Per-query overhead between the last SCAN address and the next LOAD0 address is <=8 cycles.
- Outputs outside their strobe: o_match_valid=0, and o_match_value and o_match_distance hold their last value.
- Address widths: upper address bits above 11 are always 0. Length values >2048 are clamped to 2048 and never wrap.
- Ready asserted while not in IDLE is ignored until the FSM returns to IDLE. The buffers hold ready until acked, so no request is lost.
- i_desc_*_ready low for either image keeps the FSM in IDLE indefinitely.
- Read enables are high only during the cycles their address is valid. en=0 otherwise.

Test Plan:
- L0=1, L1=1, identical descriptors, loc0=0x0010_0020, loc1=0x0030_0040 -> one valid, distance=0, value=0x0010_0020_0030_0040; start precedes valid, end follows valid.
- L0=2, L1=3; desc1 distances to desc0[0] are {10,5,5}, to desc0[1] are {3,70,80} -> records (best_j=1, dist=5) then (best_j=0, dist=3); the tie is resolved to the lower j.
- MAX_DISTANCE=64; desc1 all-ones vs desc0 all-zeros (dist 256) -> start and end pulses, no valid; best_dist registers reach 256 without overflow.
- L0=0, L1=5 -> ack pulse, start, end within 3 cycles, no reads issued.
- i_rst asserted mid-SCAN with L1=100 -> all outputs 0 next cycle, no end pulse. A subsequent ready pair restarts cleanly with a new ack.
- L0=2048, L1=2048 random -> 2048 queries, desc_1 read addresses contiguous 0..2047 per query, record count equals the golden-model count.
